// File: rtl/opo_servo_dac.sv
// OPO cavity lock actuator: triangular sweep to find resonance, bumpless hand-over
// to a PI servo, dither re-injected on the saturated 14-bit piezo DAC word.
module opo_servo_dac #(
  parameter int ERR_W  = 24,
  parameter int NCO_W  = 16,
  parameter int DAC_W  = 14,
  parameter int GAIN_W = 16,
  parameter int SHIFT  = 20,
  parameter int ACQ_N  = 4,
  parameter int LOSS_N = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     user_cntr,
  input  logic signed [ERR_W-1:0]  err_in,
  input  logic                     err_valid,
  input  logic signed [NCO_W-1:0]  dither_in,
  input  logic signed [GAIN_W-1:0] kp,
  input  logic signed [GAIN_W-1:0] ki,
  input  logic        [3:0]        dither_amp,
  input  logic        [DAC_W-1:0]  sweep_step,
  input  logic        [ERR_W-1:0]  lock_thresh,
  output logic signed [DAC_W-1:0]  dac_out,
  output logic                     dac_valid,
  output logic                     locked,
  output logic        [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_LOCK  = 2'd2
  } state_e;

  localparam int PROD_W  = ERR_W + GAIN_W;
  localparam int ACC_W   = PROD_W + 2;
  localparam int SW_W    = DAC_W + 2;
  localparam int CNT_MAX = (ACQ_N > LOSS_N) ? ACQ_N : LOSS_N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic signed [DAC_W-1:0] ACT_HI = {1'b0, {(DAC_W-1){1'b1}}};
  localparam logic signed [DAC_W-1:0] ACT_LO = {1'b1, {(DAC_W-1){1'b0}}};

  localparam logic signed [ACC_W-1:0] ONE_A    = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACT_HI_A = (ONE_A <<< (DAC_W-1)) - ONE_A;
  localparam logic signed [ACC_W-1:0] ACT_LO_A = -(ONE_A <<< (DAC_W-1));
  localparam logic signed [ACC_W-1:0] INT_HI   = ((ONE_A <<< (DAC_W-1)) <<< SHIFT) - ONE_A;
  localparam logic signed [ACC_W-1:0] INT_LO   = ACT_LO_A <<< SHIFT;

  localparam logic signed [SW_W-1:0] ONE_S    = SW_W'(1);
  localparam logic signed [SW_W-1:0] ACT_HI_S = (ONE_S <<< (DAC_W-1)) - ONE_S;
  localparam logic signed [SW_W-1:0] ACT_LO_S = -(ONE_S <<< (DAC_W-1));

  function automatic logic signed [DAC_W-1:0] sat_dac(input logic signed [ACC_W-1:0] v);
    if (v > ACT_HI_A)      return ACT_HI;
    else if (v < ACT_LO_A) return ACT_LO;
    else                   return v[DAC_W-1:0];
  endfunction

  // Stage 1: |err| and both gain products
  logic        [ERR_W:0]    abs_s1_d, abs_s1_q;
  logic signed [PROD_W-1:0] p_s1_d, p_s1_q;
  logic signed [PROD_W-1:0] i_s1_d, i_s1_q;
  logic                     vld_s1_d, vld_s1_q;

  always_comb begin
    abs_s1_d = err_in[ERR_W-1] ? (~{1'b1, err_in} + (ERR_W+1)'(1)) : {1'b0, err_in};
    p_s1_d   = PROD_W'(kp) * PROD_W'(err_in);
    i_s1_d   = PROD_W'(ki) * PROD_W'(err_in);
    vld_s1_d = err_valid & user_cntr;
  end

  // Stage 2: sequencer, integrator, actuator
  state_e                   state_d, state_q;
  logic signed [DAC_W-1:0]  act_d, act_q;
  logic signed [ACC_W-1:0]  integ_d, integ_q;
  logic        [CNT_W-1:0]  cnt_d, cnt_q;
  logic                     dir_dn_d, dir_dn_q;

  logic                     in_thr;
  logic        [CNT_W-1:0]  cnt_inc;
  logic signed [SW_W-1:0]   sweep_nx;
  logic signed [ACC_W-1:0]  integ_sum, integ_cl, pi_sum;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    integ_d  = integ_q;
    cnt_d    = cnt_q;
    dir_dn_d = dir_dn_q;

    in_thr   = abs_s1_q < {1'b0, lock_thresh};
    cnt_inc  = cnt_q + CNT_W'(1);
    sweep_nx = dir_dn_q ? SW_W'(act_q) - $signed({2'b00, sweep_step})
                        : SW_W'(act_q) + $signed({2'b00, sweep_step});

    integ_sum = integ_q + ACC_W'(i_s1_q);
    if (integ_sum > INT_HI)      integ_cl = INT_HI;
    else if (integ_sum < INT_LO) integ_cl = INT_LO;
    else                         integ_cl = integ_sum;
    pi_sum = ACC_W'(p_s1_q) + integ_cl;

    if (!user_cntr) begin
      state_d  = ST_IDLE;
      act_d    = '0;
      integ_d  = '0;
      cnt_d    = '0;
      dir_dn_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_SWEEP;
          act_d    = '0;
          integ_d  = '0;
          cnt_d    = '0;
          dir_dn_d = 1'b0;
        end
        ST_SWEEP: if (vld_s1_q) begin
          if (!dir_dn_q && sweep_nx >= ACT_HI_S) begin
            act_d    = ACT_HI;
            dir_dn_d = 1'b1;
          end else if (dir_dn_q && sweep_nx <= ACT_LO_S) begin
            act_d    = ACT_LO;
            dir_dn_d = 1'b0;
          end else begin
            act_d = sweep_nx[DAC_W-1:0];
          end
          if (!in_thr) begin
            cnt_d = '0;
          end else if (cnt_inc == CNT_W'(ACQ_N)) begin
            // Preloading the integrator makes the servo start from the sweep position.
            state_d = ST_LOCK;
            cnt_d   = '0;
            integ_d = ACC_W'(act_d) <<< SHIFT;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_LOCK: if (vld_s1_q) begin
          integ_d = integ_cl;
          act_d   = sat_dac(pi_sum >>> SHIFT);
          if (in_thr) begin
            cnt_d = '0;
          end else if (cnt_inc == CNT_W'(LOSS_N)) begin
            state_d  = ST_SWEEP;
            cnt_d    = '0;
            dir_dn_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Stage 3: dither injection and output register
  logic signed [DAC_W-1:0] dith;
  logic signed [DAC_W:0]   out_sum;
  logic signed [DAC_W-1:0] dac_out_d, dac_out_q;
  logic                    dac_valid_d, dac_valid_q;
  logic                    locked_d, locked_q;

  always_comb begin
    dith        = DAC_W'(dither_in >>> (5'(NCO_W - DAC_W) + 5'(dither_amp)));
    out_sum     = (DAC_W+1)'(act_q) + (DAC_W+1)'(dith);
    dac_out_d   = (state_q == ST_IDLE) ? '0 : sat_dac(ACC_W'(out_sum));
    dac_valid_d = (state_d != ST_IDLE);
    locked_d    = (state_d == ST_LOCK);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      abs_s1_q    <= '0;
      p_s1_q      <= '0;
      i_s1_q      <= '0;
      vld_s1_q    <= 1'b0;
      state_q     <= ST_IDLE;
      act_q       <= '0;
      integ_q     <= '0;
      cnt_q       <= '0;
      dir_dn_q    <= 1'b0;
      dac_out_q   <= '0;
      dac_valid_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      abs_s1_q    <= abs_s1_d;
      p_s1_q      <= p_s1_d;
      i_s1_q      <= i_s1_d;
      vld_s1_q    <= vld_s1_d;
      state_q     <= state_d;
      act_q       <= act_d;
      integ_q     <= integ_d;
      cnt_q       <= cnt_d;
      dir_dn_q    <= dir_dn_d;
      dac_out_q   <= dac_out_d;
      dac_valid_q <= dac_valid_d;
      locked_q    <= locked_d;
    end
  end

  assign dac_out   = dac_out_q;
  assign dac_valid = dac_valid_q;
  assign locked    = locked_q;
  assign state     = state_q;

endmodule
